pwr_seq_mon: RTL and testbench
==============================

PWR_SEQ_MON -- requirements
Module: pwr_seq_mon

Interface
REQ-001 Parameter DEBOUNCE, default 16: consecutive synchronized cycles that confirm an ERROR_N level change, range 2..255.
REQ-002 Parameter RAMP_TIMEOUT, default 1024: maximum cycles allowed in RAMP before a fault is declared, range DEBOUNCE+1..65535.
REQ-003 Parameter RETRY_HOLDOFF, default 4096: cycles spent in FAULT before an automatic retry, range 1..65535.
REQ-004 CLK  input  1  system clock; all state changes on the rising edge.
REQ-005 RST_N  input  1  reset, synchronous and active-low.
REQ-006 START  input  1  power-on request, level sampled each cycle.
REQ-007 STOP  input  1  power-off request.
REQ-008 CLEAR  input  1  fault acknowledge; also zeroes FAULT_CNT.
REQ-009 ERROR_N  input  1  regulator error flag, asynchronous, active-low (low = output out of regulation).
REQ-010 ENABLE  output  1  regulator enable.
REQ-011 PWR_GOOD  output  1  supply confirmed in regulation.
REQ-012 FAULT  output  1  fault latched.
REQ-013 STATE  output  2  current state: OFF=00, RAMP=01, GOOD=10, FAULT=11.
REQ-014 FAULT_CNT  output  8  count of FAULT entries, saturating.

Function
REQ-015 ERROR_N shall pass through a 2-flop synchronizer before any use.
REQ-016 The debounce counter shall clear whenever the synchronized level differs from the previous cycle's level, and shall otherwise increment, saturating at DEBOUNCE.
REQ-017 A level is confirmed when the debounce counter reaches DEBOUNCE.
- Confirmed-low is first visible DEBOUNCE+2 cycles after ERROR_N is first sampled low and held low.
REQ-018 All outputs shall be registered, with one cycle from the triggering condition to the output change.
REQ-019 State OFF:
- ENABLE=0, PWR_GOOD=0, FAULT=0.
- START=1 and STOP=0 goes to RAMP.
REQ-020 State RAMP:
- ENABLE=1.
- The ramp counter clears on entry and increments each cycle.
- Confirmed-high goes to GOOD.
- Ramp counter = RAMP_TIMEOUT-1 without confirmed-high goes to FAULT.
REQ-021 State GOOD:
- ENABLE=1, PWR_GOOD=1.
- Confirmed-low goes to FAULT.
REQ-022 State FAULT:
- ENABLE=0, PWR_GOOD=0, FAULT=1.
- CLEAR or STOP goes to OFF.
REQ-023 FAULT_CNT shall increment by 1 on each entry to FAULT and saturate at 255.
- CLEAR zeroes it in any state.
- When CLEAR coincides with a FAULT entry, FAULT_CNT shall result in 0.
REQ-024 Transition priority: STOP > fault/timeout detection > confirmed-high > START.
- STOP in RAMP or GOOD goes to OFF, even if a fault is detected in the same cycle.
REQ-025 The debounce counter shall clear on every state entry, so confirmation always needs DEBOUNCE fresh cycles.
REQ-026 START held high in GOOD shall have no effect, and START in FAULT shall be ignored.

Reset
REQ-027 On a RST_N=0 sample, the next state shall be:
- STATE=OFF.
- ENABLE=0, PWR_GOOD=0, FAULT=0.
- FAULT_CNT=0.
- Counters and synchronizer flops cleared to the "good" level (1).
REQ-028 Reset mid-RAMP or mid-GOOD shall drop ENABLE on the next edge, with no FAULT and no FAULT_CNT increment.

Configuration
REQ-029 Macro PWR_SEQ_AUTO_RETRY_EN:
- When defined, a holdoff counter clears on FAULT entry, and at RETRY_HOLDOFF-1 the block goes to RAMP unless CLEAR or STOP is active (CLEAR or STOP wins).
- When undefined, FAULT is held until CLEAR or STOP, and no holdoff counter is built.

Verification (DEBOUNCE=4, RAMP_TIMEOUT=32, RETRY_HOLDOFF=8)
REQ-030 Reset, START pulse, ERROR_N high throughout -> RAMP/ENABLE=1 one cycle after START; PWR_GOOD=1 by DEBOUNCE+2=6 cycles after RAMP entry.
REQ-031 In GOOD, ERROR_N low for 3 cycles -> no fault; ERROR_N low and held -> FAULT=1, ENABLE=0 exactly 6 cycles after the first low sample; FAULT_CNT=1.
REQ-032 START with ERROR_N stuck low -> FAULT 32 cycles after RAMP entry; with PWR_SEQ_AUTO_RETRY_EN, RAMP re-entered 8 cycles later; after 300 timeouts FAULT_CNT=255.
REQ-033 STOP and confirmed-low in the same GOOD cycle -> OFF, FAULT=0, FAULT_CNT unchanged.
REQ-034 RST_N=0 during RAMP -> STATE=OFF and ENABLE=0 on the next edge; CLEAR in FAULT -> OFF with FAULT_CNT=0.

Source files
------------

// File: rtl/pwr_seq_mon.sv
`default_nettype none
// ============================================================================
// Module      : pwr_seq_mon
// Description : Power-rail sequencer and monitor. Enables a regulator on
//               request, waits for its debounced error flag to confirm
//               regulation, and latches a fault on timeout or loss of
//               regulation. FAULT_CNT counts fault entries (saturating).
// Options     : define PWR_SEQ_AUTO_RETRY_EN to leave FAULT automatically
//               after RETRY_HOLDOFF cycles and retry the ramp.
// Revision    : 1.0 - initial release
// ============================================================================
module pwr_seq_mon #(
    parameter int unsigned DEBOUNCE      = 16,
    parameter int unsigned RAMP_TIMEOUT  = 1024,
    parameter int unsigned RETRY_HOLDOFF = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       error_n,
    output logic       enable,
    output logic       pwr_good,
    output logic       fault,
    output logic [1:0] state,
    output logic [7:0] fault_cnt
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_RAMP  = 2'b01,
        ST_GOOD  = 2'b10,
        ST_FAULT = 2'b11
    } state_t;

    localparam logic [7:0]  DB_MAX    = 8'(DEBOUNCE);
    localparam logic [7:0]  DB_LAST   = 8'(DEBOUNCE - 1);
    localparam logic [15:0] RAMP_LAST = 16'(RAMP_TIMEOUT - 1);

    // Parameter range guards, evaluated at elaboration
    if ((DEBOUNCE < 2) || (DEBOUNCE > 255)) begin : g_bad_debounce
        $error("pwr_seq_mon: DEBOUNCE out of range 2..255");
    end
    if ((RAMP_TIMEOUT <= DEBOUNCE) || (RAMP_TIMEOUT > 65535)) begin : g_bad_ramp
        $error("pwr_seq_mon: RAMP_TIMEOUT out of range DEBOUNCE+1..65535");
    end
    if ((RETRY_HOLDOFF < 1) || (RETRY_HOLDOFF > 65535)) begin : g_bad_holdoff
        $error("pwr_seq_mon: RETRY_HOLDOFF out of range 1..65535");
    end

    state_t      cur_st;
    state_t      nxt_st;
    logic        sync1;
    logic        sync2;
    logic        level_q;
    logic [7:0]  db_cnt;
    logic [15:0] ramp_cnt;
    logic        level_stable;
    logic        confirmed;
    logic        conf_high;
    logic        conf_low;
    logic        entering;
    logic        ramp_expired;
    logic        retry_due;

    // Two-flop synchronizer on the asynchronous error flag, plus a one-cycle
    // history of the synchronized level for change detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level_q <= 1'b1;
        end else begin
            sync1   <= error_n;
            sync2   <= sync1;
            level_q <= sync2;
        end
    end

    // A level counts as confirmed on the edge where the counter reaches
    // DEBOUNCE (and for as long as it stays saturated), so the FSM reacts on
    // that same edge and the registered outputs follow one cycle later.
    assign level_stable = (sync2 == level_q);
    assign confirmed    = level_stable && (db_cnt >= DB_LAST);
    assign conf_high    = confirmed && sync2;
    assign conf_low     = confirmed && !sync2;
    assign entering     = (nxt_st != cur_st);
    assign ramp_expired = (ramp_cnt == RAMP_LAST) && !conf_high;

    // Debounce counter: restarts on any level change or state entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_cnt <= '0;
        end else if (entering || !level_stable) begin
            db_cnt <= '0;
        end else if (db_cnt != DB_MAX) begin
            db_cnt <= db_cnt + 8'd1;
        end
    end

    // Ramp counter: held at zero outside RAMP, so it starts at 0 on entry
    always_ff @(posedge clk) begin
        if (!rst_n || (cur_st != ST_RAMP)) begin
            ramp_cnt <= '0;
        end else begin
            ramp_cnt <= ramp_cnt + 16'd1;
        end
    end

`ifdef PWR_SEQ_AUTO_RETRY_EN
    localparam logic [15:0] HOLD_LAST = 16'(RETRY_HOLDOFF - 1);
    logic [15:0] hold_cnt;

    // Retry holdoff counter: held at zero outside FAULT
    always_ff @(posedge clk) begin
        if (!rst_n || (cur_st != ST_FAULT)) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + 16'd1;
        end
    end

    assign retry_due = (hold_cnt == HOLD_LAST);
`else
    assign retry_due = 1'b0;
`endif

    // Next-state logic; STOP outranks fault/timeout, which outranks good
    always_comb begin
        nxt_st = cur_st;
        case (cur_st)
            ST_OFF: begin
                if (start && !stop) nxt_st = ST_RAMP;
            end
            ST_RAMP: begin
                if (stop)              nxt_st = ST_OFF;
                else if (ramp_expired) nxt_st = ST_FAULT;
                else if (conf_high)    nxt_st = ST_GOOD;
            end
            ST_GOOD: begin
                if (stop)          nxt_st = ST_OFF;
                else if (conf_low) nxt_st = ST_FAULT;
            end
            ST_FAULT: begin
                if (clear || stop)  nxt_st = ST_OFF;
                else if (retry_due) nxt_st = ST_RAMP;
            end
            default: nxt_st = ST_OFF;
        endcase
    end

    // State register with outputs registered from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_st   <= ST_OFF;
            enable   <= 1'b0;
            pwr_good <= 1'b0;
            fault    <= 1'b0;
        end else begin
            cur_st   <= nxt_st;
            enable   <= (nxt_st == ST_RAMP) || (nxt_st == ST_GOOD);
            pwr_good <= (nxt_st == ST_GOOD);
            fault    <= (nxt_st == ST_FAULT);
        end
    end

    // Fault entry counter; CLEAR wins even over a simultaneous entry
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            fault_cnt <= '0;
        end else if ((nxt_st == ST_FAULT) && (cur_st != ST_FAULT) && (fault_cnt != 8'hFF)) begin
            fault_cnt <= fault_cnt + 8'd1;
        end
    end

    assign state = cur_st;

endmodule
`default_nettype wire

// File: tb/tb_pwr_seq_mon.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwr_seq_mon
// Description : Directed scoreboard bench for pwr_seq_mon (DEBOUNCE=4,
//               RAMP_TIMEOUT=32, RETRY_HOLDOFF=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwr_seq_mon;

    localparam logic [1:0] S_OFF   = 2'b00;
    localparam logic [1:0] S_RAMP  = 2'b01;
    localparam logic [1:0] S_GOOD  = 2'b10;
    localparam logic [1:0] S_FAULT = 2'b11;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       start   = 1'b0;
    logic       stop    = 1'b0;
    logic       clear   = 1'b0;
    logic       error_n = 1'b1;
    logic       enable;
    logic       pwr_good;
    logic       fault;
    logic [1:0] state;
    logic [7:0] fault_cnt;

    int cyc      = 0;
    int n_checks = 0;
    int n_fails  = 0;

    // Scoreboard: target cycle, name and expected {state,en,pg,fault,cnt}
    int          q_cyc[$];
    string       q_name[$];
    logic [12:0] q_exp[$];

    pwr_seq_mon #(
        .DEBOUNCE      (4),
        .RAMP_TIMEOUT  (32),
        .RETRY_HOLDOFF (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .error_n   (error_n),
        .enable    (enable),
        .pwr_good  (pwr_good),
        .fault     (fault),
        .state     (state),
        .fault_cnt (fault_cnt)
    );

    // Clock generation
    always #5 clk = ~clk;

    // Rising-edge counter used to time expectations
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops every expectation due this cycle and compares
    always @(negedge clk) begin
        logic [12:0] act;
        act = {state, enable, pwr_good, fault, fault_cnt};
        while ((q_cyc.size() > 0) && (q_cyc[0] <= cyc)) begin
            n_checks++;
            if ((q_cyc[0] != cyc) || (act !== q_exp[0])) begin
                n_fails++;
                $display("FAIL %s @cyc %0d: got state=%0d en=%0b pg=%0b fault=%0b cnt=%0d, want state=%0d en=%0b pg=%0b fault=%0b cnt=%0d (due cyc %0d)",
                         q_name[0], cyc, act[12:11], act[10], act[9], act[8], act[7:0],
                         q_exp[0][12:11], q_exp[0][10], q_exp[0][9], q_exp[0][8], q_exp[0][7:0], q_cyc[0]);
            end
            void'(q_cyc.pop_front());
            void'(q_name.pop_front());
            void'(q_exp.pop_front());
        end
    end

    // Push an expectation dly rising edges ahead, kept sorted by cycle
    task automatic chk(input int dly, input string nm, input logic [1:0] st,
                       input logic en, input logic pg, input logic f, input logic [7:0] cnt);
        int tgt;
        int idx;
        tgt = cyc + dly;
        idx = q_cyc.size();
        while ((idx > 0) && (q_cyc[idx-1] > tgt)) idx--;
        q_cyc.insert(idx, tgt);
        q_name.insert(idx, nm);
        q_exp.insert(idx, {st, en, pg, f, cnt});
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset state
        chk(2, "reset", S_OFF, 1'b0, 1'b0, 1'b0, 8'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Power-up with ERROR_N high; START held into GOOD has no effect
        start = 1'b1;
        chk(1, "ramp_entry",    S_RAMP, 1'b1, 1'b0, 1'b0, 8'd0);
        chk(4, "ramp_hold",     S_RAMP, 1'b1, 1'b0, 1'b0, 8'd0);
        chk(5, "good",          S_GOOD, 1'b1, 1'b1, 1'b0, 8'd0);
        chk(7, "start_in_good", S_GOOD, 1'b1, 1'b1, 1'b0, 8'd0);
        tick(8);
        start = 1'b0;

        // 3-cycle glitch low: filtered
        error_n = 1'b0;
        chk(8,  "glitch_a", S_GOOD, 1'b1, 1'b1, 1'b0, 8'd0);
        chk(12, "glitch_b", S_GOOD, 1'b1, 1'b1, 1'b0, 8'd0);
        tick(3);
        error_n = 1'b1;
        tick(12);

        // Held low: FAULT six cycles after first low sample
        error_n = 1'b0;
        chk(6, "pre_fault", S_GOOD,  1'b1, 1'b1, 1'b0, 8'd0);
        chk(7, "lost_reg",  S_FAULT, 1'b0, 1'b0, 1'b1, 8'd1);
        tick(7);
        start = 1'b1;
        chk(2, "start_in_fault", S_FAULT, 1'b0, 1'b0, 1'b1, 8'd1);
        tick(2);
        start = 1'b0;
        stop  = 1'b1;
        chk(1, "stop_from_fault", S_OFF, 1'b0, 1'b0, 1'b0, 8'd1);
        tick(1);
        stop    = 1'b0;
        error_n = 1'b1;
        tick(10);

        // STOP coincides with confirmed-low in GOOD: STOP wins
        start = 1'b1;
        chk(5, "good_again", S_GOOD, 1'b1, 1'b1, 1'b0, 8'd1);
        tick(1);
        start = 1'b0;
        tick(5);
        error_n = 1'b0;
        chk(6, "stop_race_pre", S_GOOD, 1'b1, 1'b1, 1'b0, 8'd1);
        chk(7, "stop_wins",     S_OFF,  1'b0, 1'b0, 1'b0, 8'd1);
        tick(6);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(10);

        // Ramp timeout with ERROR_N stuck low, then CLEAR from FAULT
        start = 1'b1;
        chk(1,  "to_ramp",      S_RAMP,  1'b1, 1'b0, 1'b0, 8'd1);
        chk(32, "to_ramp_last", S_RAMP,  1'b1, 1'b0, 1'b0, 8'd1);
        chk(33, "timeout",      S_FAULT, 1'b0, 1'b0, 1'b1, 8'd2);
`ifdef PWR_SEQ_AUTO_RETRY_EN
        chk(40, "holdoff_last", S_FAULT, 1'b0, 1'b0, 1'b1, 8'd2);
        chk(41, "retry",        S_RAMP,  1'b1, 1'b0, 1'b0, 8'd2);
        chk(73, "timeout2",     S_FAULT, 1'b0, 1'b0, 1'b1, 8'd3);
        tick(1);
        start = 1'b0;
        tick(72);
`else
        chk(45, "fault_held",   S_FAULT, 1'b0, 1'b0, 1'b1, 8'd2);
        tick(1);
        start = 1'b0;
        tick(44);
`endif
        clear = 1'b1;
        chk(1, "clear_fault", S_OFF, 1'b0, 1'b0, 1'b0, 8'd0);
        tick(1);
        clear = 1'b0;

        // 300 timeouts: FAULT_CNT saturates at 255
        for (int i = 0; i < 300; i++) begin
            logic [7:0] exp_cnt;
            exp_cnt = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
            start = 1'b1;
            chk(33, "sat_fault", S_FAULT, 1'b0, 1'b0, 1'b1, exp_cnt);
            tick(1);
            start = 1'b0;
            tick(32);
            stop = 1'b1;
            chk(1, "sat_off", S_OFF, 1'b0, 1'b0, 1'b0, exp_cnt);
            tick(1);
            stop = 1'b0;
        end

        // CLEAR coinciding with a FAULT entry leaves FAULT_CNT at 0
        start = 1'b1;
        chk(33, "clear_at_entry", S_FAULT, 1'b0, 1'b0, 1'b1, 8'd0);
        tick(1);
        start = 1'b0;
        tick(31);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        stop  = 1'b1;
        chk(1, "stop_after_clr", S_OFF, 1'b0, 1'b0, 1'b0, 8'd0);
        tick(1);
        stop    = 1'b0;
        error_n = 1'b1;
        tick(10);

        // Reset during RAMP drops ENABLE on the next edge
        start = 1'b1;
        chk(1, "rst_pre_ramp", S_RAMP, 1'b1, 1'b0, 1'b0, 8'd0);
        chk(3, "rst_in_ramp",  S_OFF,  1'b0, 1'b0, 1'b0, 8'd0);
        tick(1);
        start = 1'b0;
        tick(1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(3);

        n_checks++;
        if (q_cyc.size() != 0) begin
            n_fails++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", q_cyc.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
